// File: rtl/control_unit.sv
// Multicycle CPU control FSM: decodes opcode/funct and ALU flags into datapath
// write enables and mux selects. Moore outputs, except the branch PCWrite which follows zero.
module control_unit #(
   parameter int SP_INIT = 227
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       AWrite,
   output logic       BWrite,
   output logic       ALUOutWrite,
   output logic       MDRWrite,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] RegDst,
   output logic [1:0] DataSrc,
   output logic [1:0] PCSource,
   output logic       halted,
   output logic [4:0] state
);

   typedef enum logic [4:0] {
      S_RESET      = 5'd0,
      S_FETCH      = 5'd1,
      S_FETCH_WAIT = 5'd2,
      S_DECODE     = 5'd3,
      S_R_EXEC     = 5'd4,
      S_R_WB       = 5'd5,
      S_ADDI_EXEC  = 5'd6,
      S_ADDI_WB    = 5'd7,
      S_MEM_ADDR   = 5'd8,
      S_LW_READ    = 5'd9,
      S_LW_WAIT    = 5'd10,
      S_LW_WB      = 5'd11,
      S_SW_WRITE   = 5'd12,
      S_BRANCH     = 5'd13,
      S_JUMP       = 5'd14,
      S_HALT       = 5'd15
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_BREAK = 6'h0D;

   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;

   // The stack-pointer value itself lives in the datapath; only its range is checked here.
   if (SP_INIT < 0) begin : g_sp_init_check
      $error("SP_INIT must be non-negative");
   end

   state_e state_q, state_d;

   logic r_arith;
   assign r_arith = (funct == FN_ADD) || (funct == FN_SUB);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:      state_d = S_FETCH;
         S_FETCH:      state_d = S_FETCH_WAIT;
         S_FETCH_WAIT: state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
                     state_d = S_R_EXEC;
                  end else begin
                     state_d = S_HALT;
                  end
               end
               OP_ADDI:       state_d = S_ADDI_EXEC;
               OP_LW, OP_SW:  state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               default:       state_d = S_HALT;
            endcase
         end
         S_R_EXEC:     state_d = (overflow && r_arith) ? S_HALT : S_R_WB;
         S_R_WB:       state_d = S_FETCH;
         S_ADDI_EXEC:  state_d = overflow ? S_HALT : S_ADDI_WB;
         S_ADDI_WB:    state_d = S_FETCH;
         S_MEM_ADDR:   state_d = (opcode == OP_SW) ? S_SW_WRITE : S_LW_READ;
         S_LW_READ:    state_d = S_LW_WAIT;
         S_LW_WAIT:    state_d = S_LW_WB;
         S_LW_WB:      state_d = S_FETCH;
         S_SW_WRITE:   state_d = S_FETCH;
         S_BRANCH:     state_d = S_FETCH;
         S_JUMP:       state_d = S_FETCH;
         S_HALT:       state_d = S_HALT;
         default:      state_d = S_HALT;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      AWrite      = 1'b0;
      BWrite      = 1'b0;
      ALUOutWrite = 1'b0;
      MDRWrite    = 1'b0;
      IorD        = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 3'b000;
      RegDst      = 2'b00;
      DataSrc     = 2'b00;
      PCSource    = 2'b00;
      halted      = 1'b0;
      case (state_q)
         S_RESET: begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            DataSrc  = 2'b10;
         end
         S_FETCH: begin
            IorD = 1'b0;
         end
         S_FETCH_WAIT: begin
            IRWrite  = 1'b1;
            PCWrite  = 1'b1;
            ALUSrcB  = 2'b01;
            ALUOp    = ALU_ADD;
            PCSource = 2'b00;
         end
         S_DECODE: begin
            AWrite      = 1'b1;
            BWrite      = 1'b1;
            ALUOutWrite = 1'b1;
            ALUSrcB     = 2'b11;
            ALUOp       = ALU_ADD;
         end
         S_R_EXEC: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b00;
            ALUOutWrite = 1'b1;
            case (funct)
               FN_ADD:  ALUOp = ALU_ADD;
               FN_SUB:  ALUOp = ALU_SUB;
               FN_AND:  ALUOp = ALU_AND;
               default: ALUOp = 3'b000;
            endcase
         end
         S_R_WB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
            DataSrc  = 2'b00;
         end
         S_ADDI_EXEC, S_MEM_ADDR: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ALUOp       = ALU_ADD;
            ALUOutWrite = 1'b1;
         end
         S_ADDI_WB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b00;
            DataSrc  = 2'b00;
         end
         S_LW_READ: begin
            IorD = 1'b1;
         end
         S_LW_WAIT: begin
            IorD     = 1'b1;
            MDRWrite = 1'b1;
         end
         S_LW_WB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b00;
            DataSrc  = 2'b01;
         end
         S_SW_WRITE: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = 2'b00;
            ALUOp    = ALU_SUB;
            PCSource = 2'b01;
            // zero comes from the compare running this very cycle
            PCWrite  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            halted = 1'b1;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle vector table plus hand-written
// sequences for overflow halt, halt hold and reset mid-load.
module tb_control_unit;

   logic       clock = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       zero, overflow;
   logic       PCWrite, MemWrite, IRWrite, RegWrite, AWrite, BWrite, ALUOutWrite, MDRWrite;
   logic       IorD, ALUSrcA, halted;
   logic [1:0] ALUSrcB, RegDst, DataSrc, PCSource;
   logic [2:0] ALUOp;
   logic [4:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   control_unit #(.SP_INIT(227)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .zero(zero), .overflow(overflow),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .AWrite(AWrite), .BWrite(BWrite), .ALUOutWrite(ALUOutWrite), .MDRWrite(MDRWrite),
      .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .RegDst(RegDst), .DataSrc(DataSrc), .PCSource(PCSource),
      .halted(halted), .state(state)
   );

   localparam logic [4:0] RST = 5'd0,  FE  = 5'd1,  FW  = 5'd2,  DE  = 5'd3;
   localparam logic [4:0] RX  = 5'd4,  RWB = 5'd5,  AX  = 5'd6,  AWB = 5'd7;
   localparam logic [4:0] MA  = 5'd8,  LR  = 5'd9,  LWT = 5'd10, LWB = 5'd11;
   localparam logic [4:0] SWW = 5'd12, BR  = 5'd13, JP  = 5'd14, HLT = 5'd15;

   logic [21:0] act;
   assign act = {PCWrite, MemWrite, IRWrite, RegWrite, AWrite, BWrite, ALUOutWrite, MDRWrite,
                 IorD, ALUSrcA, ALUSrcB, ALUOp, RegDst, DataSrc, PCSource, halted};

   function automatic logic [21:0] mk(input logic pcw, memw, irw, regw, aw, bw, aluow, mdrw,
                                      input logic iord, srca, input logic [1:0] srcb,
                                      input logic [2:0] aluop, input logic [1:0] regdst,
                                      input logic [1:0] datasrc, input logic [1:0] pcsrc,
                                      input logic hlt);
      return {pcw, memw, irw, regw, aw, bw, aluow, mdrw, iord, srca, srcb, aluop,
              regdst, datasrc, pcsrc, hlt};
   endfunction

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       ov;
      logic [4:0] st;
      logic [21:0] out;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic ov, input logic [4:0] st,
                              input logic [21:0] out);
      vec_t r;
      r.rst = rst; r.op = op; r.fn = fn; r.z = z; r.ov = ov; r.st = st; r.out = out;
      return r;
   endfunction

   // One cycle: drive at negedge, compare shortly after, then let the next posedge happen.
   task automatic step(input vec_t t, input string name);
      @(negedge clock);
      reset = t.rst; opcode = t.op; funct = t.fn; zero = t.z; overflow = t.ov;
      #1;
      checks++;
      if (state !== t.st) begin
         errors++;
         $display("FAIL %s state: got %0d expected %0d", name, state, t.st);
      end
      checks++;
      if (act !== t.out) begin
         errors++;
         $display("FAIL %s outputs: got %h expected %h", name, act, t.out);
      end
   endtask

   logic [21:0] O_RST, O_FE, O_FW, O_DE, O_RXADD, O_RXSUB, O_RXAND, O_RWB, O_AX, O_AWB;
   logic [21:0] O_LR, O_LWT, O_LWB, O_SWW, O_BRT, O_BRN, O_JP, O_HLT;

   initial begin
      O_RST   = mk(0,0,0,1, 0,0,0,0, 0,0,2'b00,3'b000, 2'b10,2'b10,2'b00, 0);
      O_FE    = mk(0,0,0,0, 0,0,0,0, 0,0,2'b00,3'b000, 2'b00,2'b00,2'b00, 0);
      O_FW    = mk(1,0,1,0, 0,0,0,0, 0,0,2'b01,3'b001, 2'b00,2'b00,2'b00, 0);
      O_DE    = mk(0,0,0,0, 1,1,1,0, 0,0,2'b11,3'b001, 2'b00,2'b00,2'b00, 0);
      O_RXADD = mk(0,0,0,0, 0,0,1,0, 0,1,2'b00,3'b001, 2'b00,2'b00,2'b00, 0);
      O_RXSUB = mk(0,0,0,0, 0,0,1,0, 0,1,2'b00,3'b010, 2'b00,2'b00,2'b00, 0);
      O_RXAND = mk(0,0,0,0, 0,0,1,0, 0,1,2'b00,3'b011, 2'b00,2'b00,2'b00, 0);
      O_RWB   = mk(0,0,0,1, 0,0,0,0, 0,0,2'b00,3'b000, 2'b01,2'b00,2'b00, 0);
      O_AX    = mk(0,0,0,0, 0,0,1,0, 0,1,2'b10,3'b001, 2'b00,2'b00,2'b00, 0);
      O_AWB   = mk(0,0,0,1, 0,0,0,0, 0,0,2'b00,3'b000, 2'b00,2'b00,2'b00, 0);
      O_LR    = mk(0,0,0,0, 0,0,0,0, 1,0,2'b00,3'b000, 2'b00,2'b00,2'b00, 0);
      O_LWT   = mk(0,0,0,0, 0,0,0,1, 1,0,2'b00,3'b000, 2'b00,2'b00,2'b00, 0);
      O_LWB   = mk(0,0,0,1, 0,0,0,0, 0,0,2'b00,3'b000, 2'b00,2'b01,2'b00, 0);
      O_SWW   = mk(0,1,0,0, 0,0,0,0, 1,0,2'b00,3'b000, 2'b00,2'b00,2'b00, 0);
      O_BRT   = mk(1,0,0,0, 0,0,0,0, 0,1,2'b00,3'b010, 2'b00,2'b00,2'b01, 0);
      O_BRN   = mk(0,0,0,0, 0,0,0,0, 0,1,2'b00,3'b010, 2'b00,2'b00,2'b01, 0);
      O_JP    = mk(1,0,0,0, 0,0,0,0, 0,0,2'b00,3'b000, 2'b00,2'b00,2'b10, 0);
      O_HLT   = mk(0,0,0,0, 0,0,0,0, 0,0,2'b00,3'b000, 2'b00,2'b00,2'b00, 1);

      // reset held three cycles
      tbl.push_back(v(1, 6'h00, 6'h20, 0, 0, RST, O_RST));
      tbl.push_back(v(1, 6'h00, 6'h20, 0, 0, RST, O_RST));
      tbl.push_back(v(0, 6'h00, 6'h20, 0, 0, RST, O_RST));
      // add
      tbl.push_back(v(0, 6'h00, 6'h20, 0, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h00, 6'h20, 0, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h00, 6'h20, 0, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h00, 6'h20, 0, 0, RX,  O_RXADD));
      tbl.push_back(v(0, 6'h00, 6'h20, 0, 0, RWB, O_RWB));
      // sub
      tbl.push_back(v(0, 6'h00, 6'h22, 0, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h00, 6'h22, 0, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h00, 6'h22, 0, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h00, 6'h22, 0, 0, RX,  O_RXSUB));
      tbl.push_back(v(0, 6'h00, 6'h22, 0, 0, RWB, O_RWB));
      // and: overflow flag is irrelevant for a logical op
      tbl.push_back(v(0, 6'h00, 6'h24, 0, 1, FE,  O_FE));
      tbl.push_back(v(0, 6'h00, 6'h24, 0, 1, FW,  O_FW));
      tbl.push_back(v(0, 6'h00, 6'h24, 0, 1, DE,  O_DE));
      tbl.push_back(v(0, 6'h00, 6'h24, 0, 1, RX,  O_RXAND));
      tbl.push_back(v(0, 6'h00, 6'h24, 0, 1, RWB, O_RWB));
      // lw
      tbl.push_back(v(0, 6'h23, 6'h00, 0, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h23, 6'h00, 0, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h23, 6'h00, 0, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h23, 6'h00, 0, 0, MA,  O_AX));
      tbl.push_back(v(0, 6'h23, 6'h00, 0, 0, LR,  O_LR));
      tbl.push_back(v(0, 6'h23, 6'h00, 0, 0, LWT, O_LWT));
      tbl.push_back(v(0, 6'h23, 6'h00, 0, 0, LWB, O_LWB));
      // sw
      tbl.push_back(v(0, 6'h2B, 6'h00, 0, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h2B, 6'h00, 0, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h2B, 6'h00, 0, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h2B, 6'h00, 0, 0, MA,  O_AX));
      tbl.push_back(v(0, 6'h2B, 6'h00, 0, 0, SWW, O_SWW));
      // beq taken / not taken, bne taken / not taken
      tbl.push_back(v(0, 6'h04, 6'h00, 1, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h04, 6'h00, 1, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h04, 6'h00, 1, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h04, 6'h00, 1, 0, BR,  O_BRT));
      tbl.push_back(v(0, 6'h04, 6'h00, 0, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h04, 6'h00, 0, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h04, 6'h00, 0, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h04, 6'h00, 0, 0, BR,  O_BRN));
      tbl.push_back(v(0, 6'h05, 6'h00, 0, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h05, 6'h00, 0, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h05, 6'h00, 0, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h05, 6'h00, 0, 0, BR,  O_BRT));
      tbl.push_back(v(0, 6'h05, 6'h00, 1, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h05, 6'h00, 1, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h05, 6'h00, 1, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h05, 6'h00, 1, 0, BR,  O_BRN));
      // j
      tbl.push_back(v(0, 6'h02, 6'h00, 0, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h02, 6'h00, 0, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h02, 6'h00, 0, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h02, 6'h00, 0, 0, JP,  O_JP));
      // addi without overflow
      tbl.push_back(v(0, 6'h08, 6'h00, 0, 0, FE,  O_FE));
      tbl.push_back(v(0, 6'h08, 6'h00, 0, 0, FW,  O_FW));
      tbl.push_back(v(0, 6'h08, 6'h00, 0, 0, DE,  O_DE));
      tbl.push_back(v(0, 6'h08, 6'h00, 0, 0, AX,  O_AX));
      tbl.push_back(v(0, 6'h08, 6'h00, 0, 0, AWB, O_AWB));
      tbl.push_back(v(0, 6'h08, 6'h00, 0, 0, FE,  O_FE));

      reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
      @(posedge clock);

      foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

      // addi overflow -> HALT held 20 cycles, then reset recovers
      step(v(0, 6'h08, 6'h00, 0, 0, FW,  O_FW),  "ovf_fw");
      step(v(0, 6'h08, 6'h00, 0, 0, DE,  O_DE),  "ovf_de");
      step(v(0, 6'h08, 6'h00, 0, 1, AX,  O_AX),  "ovf_ax");
      for (int i = 0; i < 20; i++) step(v(0, 6'h08, 6'h00, 0, 0, HLT, O_HLT), $sformatf("halt%0d", i));
      step(v(1, 6'h08, 6'h00, 0, 0, HLT, O_HLT), "halt_rst");
      step(v(0, 6'h08, 6'h00, 0, 0, RST, O_RST), "rec_rst");
      step(v(0, 6'h00, 6'h20, 0, 0, FE,  O_FE),  "rec_fe");

      // R-type add overflow -> HALT (no R_WB)
      step(v(0, 6'h00, 6'h20, 0, 0, FW,  O_FW),    "radd_fw");
      step(v(0, 6'h00, 6'h20, 0, 0, DE,  O_DE),    "radd_de");
      step(v(0, 6'h00, 6'h20, 0, 1, RX,  O_RXADD), "radd_rx");
      step(v(1, 6'h00, 6'h20, 0, 0, HLT, O_HLT),   "radd_hlt");

      // illegal opcode halts straight after decode
      step(v(0, 6'h3F, 6'h00, 0, 0, RST, O_RST), "ill_rst");
      step(v(0, 6'h3F, 6'h00, 0, 0, FE,  O_FE),  "ill_fe");
      step(v(0, 6'h3F, 6'h00, 0, 0, FW,  O_FW),  "ill_fw");
      step(v(0, 6'h3F, 6'h00, 0, 0, DE,  O_DE),  "ill_de");
      step(v(0, 6'h3F, 6'h00, 0, 0, HLT, O_HLT), "ill_hlt");

      // break halts likewise
      step(v(1, 6'h00, 6'h0D, 0, 0, HLT, O_HLT), "brk_pre");
      step(v(0, 6'h00, 6'h0D, 0, 0, RST, O_RST), "brk_rst");
      step(v(0, 6'h00, 6'h0D, 0, 0, FE,  O_FE),  "brk_fe");
      step(v(0, 6'h00, 6'h0D, 0, 0, FW,  O_FW),  "brk_fw");
      step(v(0, 6'h00, 6'h0D, 0, 0, DE,  O_DE),  "brk_de");
      step(v(1, 6'h00, 6'h0D, 0, 0, HLT, O_HLT), "brk_hlt");

      // reset during LW_READ: no MDRWrite / load write-back follows
      step(v(0, 6'h23, 6'h00, 0, 0, RST, O_RST), "lwr_rst0");
      step(v(0, 6'h23, 6'h00, 0, 0, FE,  O_FE),  "lwr_fe");
      step(v(0, 6'h23, 6'h00, 0, 0, FW,  O_FW),  "lwr_fw");
      step(v(0, 6'h23, 6'h00, 0, 0, DE,  O_DE),  "lwr_de");
      step(v(0, 6'h23, 6'h00, 0, 0, MA,  O_AX),  "lwr_ma");
      step(v(1, 6'h23, 6'h00, 0, 0, LR,  O_LR),  "lwr_lr");
      step(v(0, 6'h23, 6'h00, 0, 0, RST, O_RST), "lwr_rst");
      step(v(0, 6'h23, 6'h00, 0, 0, FE,  O_FE),  "lwr_fe2");

      // BRANCH PCWrite follows zero within the cycle
      step(v(0, 6'h04, 6'h00, 0, 0, FW,  O_FW),  "mealy_fw");
      step(v(0, 6'h04, 6'h00, 0, 0, DE,  O_DE),  "mealy_de");
      step(v(0, 6'h04, 6'h00, 0, 0, BR,  O_BRN), "mealy_br0");
      zero = 1'b1;
      #1;
      checks++;
      if (PCWrite !== 1'b1) begin
         errors++;
         $display("FAIL mealy_br1 PCWrite: got %b expected 1", PCWrite);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
